// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory / MMIO block.
//   state_e  : controller state (RAM clear after reset, then normal service)
//   sel_e    : address-decode result
//   MMIO_BASE_DEF : default LED register address (switches sit at +1)
package dmem_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_ERR
  } sel_e;

  localparam logic [15:0] MMIO_BASE_DEF = 16'hFFF0;

endpackage

// File: rtl/dmem_mmio_if.sv
// Load/store request/response bus between the core and dmem_mmio.
//   req_valid/req_ready : request handshake, transfer when both high
//   req_we, req_addr, req_wdata : request payload
//   rsp_valid, rsp_rdata, rsp_err : one-cycle registered response
// master = core side, slave = memory side.
interface dmem_mmio_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_decode.sv
// Combinational address decoder for the data-side memory map.
//   addr : full request address
//   sel  : SEL_RAM for addr < DEPTH, SEL_LED at MMIO_BASE,
//          SEL_SW at MMIO_BASE+1, SEL_ERR otherwise
// RAM takes priority should a build ever overlap the MMIO window.
module dmem_decode
  import dmem_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 16,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(MMIO_BASE_DEF)
) (
  input  logic [ADDR_W-1:0] addr,
  output sel_e              sel
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] SW_ADDR = MMIO_BASE + ADDR_W'(1);

  always_comb begin
    sel = SEL_ERR;
    if ({1'b0, addr} < DEPTH_X) begin
      sel = SEL_RAM;
    end else if (addr == MMIO_BASE) begin
      sel = SEL_LED;
    end else if (addr == SW_ADDR) begin
      sel = SEL_SW;
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory for the 16-bit CPU: word RAM, LED output register, switch
// input register and a combinational debug read port.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request/response bus (slave side)
//   sw         : raw board switches (asynchronous, synchronised here)
//   led        : LED register
//   dbg_sel    : debug RAM index
//   dbg_data   : RAM[dbg_sel], combinational
//
// state | meaning
// INIT  | clearing RAM[clr_cnt], one word per cycle; no requests accepted
// RUN   | serving requests, req_ready high every cycle
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 16,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(MMIO_BASE_DEF),
  parameter int                SW_W      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dmem_mmio_if.slave               bus,
  input  logic [SW_W-1:0]          sw,
  output logic [DATA_W-1:0]        led,
  input  logic [$clog2(DEPTH)-1:0] dbg_sel,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e            state, state_nxt;
  logic [IDX_W-1:0]  clr_cnt, clr_nxt;
  logic              clr_we;
  logic              ready;

  sel_e              sel;
  logic              xfer;
  logic              ram_we;
  logic              led_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [DATA_W-1:0] rd_val;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    clr_we    = 1'b0;
    ready     = 1'b0;
    case (state)
      INIT: begin
        clr_we  = 1'b1;
        clr_nxt = clr_cnt + 1'b1;
        if (clr_cnt == IDX_W'(DEPTH - 1)) begin
          state_nxt = RUN;
          clr_nxt   = '0;
        end
      end
      RUN: ready = 1'b1;
      default: state_nxt = INIT;
    endcase
    // The state register only sees reset at the next edge; keep the bus
    // and the RAM quiet during the reset cycle itself.
    if (!rst_n) begin
      ready  = 1'b0;
      clr_we = 1'b0;
    end
  end

  assign bus.req_ready = ready;

  // ---------------- decode ----------------
  dmem_decode #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .MMIO_BASE(MMIO_BASE)
  ) u_decode (
    .addr(bus.req_addr),
    .sel (sel)
  );

  assign xfer    = bus.req_valid && ready;
  assign ram_idx = bus.req_addr[IDX_W-1:0];
  assign ram_we  = xfer && bus.req_we && (sel == SEL_RAM);
  assign led_we  = xfer && bus.req_we && (sel == SEL_LED);

  // ---------------- RAM ----------------
  always_ff @(posedge clk) begin
    if (clr_we) begin
      ram[clr_cnt] <= '0;
    end else if (ram_we) begin
      ram[ram_idx] <= bus.req_wdata;
    end
  end

  assign dbg_data = ram[dbg_sel];

  // ---------------- MMIO ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led     <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (led_we) begin
        led <= bus.req_wdata;
      end
    end
  end

  // ---------------- response ----------------
  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_RAM: rd_val = ram[ram_idx];
      SEL_LED: rd_val = led;
      SEL_SW:  rd_val = DATA_W'(sw_sync);
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (xfer) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_rdata <= bus.req_we ? '0 : rd_val;
      bus.rsp_err   <= (sel == SEL_ERR) || ((sel == SEL_SW) && bus.req_we);
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end
  end

endmodule
